// File: rtl/fb_pkg.sv
// Shared constants and FSM state type for the frame-buffer fetch scheduler.
package fb_pkg;
   localparam int H_AREA       = 640;
   localparam int V_AREA       = 480;
   localparam int V_TOTAL      = 525;
   localparam int SCALE_LOG2   = 2;
   localparam int WORD_W       = 8;
   localparam int X_DATA_WIDTH = 9;
   localparam int Y_DATA_WIDTH = 9;

   localparam int SRC_W       = H_AREA >> SCALE_LOG2;
   localparam int SRC_H       = V_AREA >> SCALE_LOG2;
   localparam int LINE_WORDS  = SRC_W / WORD_W;
   localparam int FRAME_WORDS = LINE_WORDS * SRC_H;
   localparam int ADDR_W      = 13;
   localparam int OFS_W       = ADDR_W - 1;
   localparam int IDX_W       = 5;

   typedef enum logic [1:0] {IDLE, FETCH, LAST} fsm_e;
endpackage

// File: rtl/fb_line_buf.sv
// Ping-pong line buffer: two source lines of LINE_WORDS words each,
// one synchronous write port and one combinational read port.
module fb_line_buf
   import fb_pkg::*;
(
   input  logic              clk_i,
   input  logic              we_i,
   input  logic              wsel_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              rsel_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [WORD_W-1:0] rdata_o
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

   logic [WORD_W-1:0] line_q [2][LINE_WORDS];

   always_ff @(posedge clk_i) begin
      if (we_i && (waddr_i <= LAST_IDX)) line_q[wsel_i][waddr_i] <= wdata_i;
   end

   // Columns past the visible area index beyond the line; read them as dark.
   always_comb begin
      rdata_o = '0;
      if (raddr_i <= LAST_IDX) rdata_o = line_q[rsel_i][raddr_i];
   end
endmodule

// File: rtl/fb_fetch_sched.sv
// Frame-buffer scheduler: line prefetch (priority) vs. streaming loader, bank swap, 4x upscale.
// Optional FB_UNDERRUN_BLANK_EN: blank lines whose prefetch was skipped by an overrun.
//
// state | meaning
// IDLE  | loader may write the back bank
// FETCH | issuing LINE_WORDS reads from the front bank
// LAST  | capturing the final read word
module fb_fetch_sched
   import fb_pkg::*;
(
   input  logic                  CLK_50,
   input  logic                  reset_n,
   input  logic                  pixel_clk_en,
   input  logic [X_DATA_WIDTH:0] x_pos,
   input  logic [Y_DATA_WIDTH:0] y_pos,
   input  logic                  ld_valid,
   input  logic [WORD_W-1:0]     ld_data,
   output logic                  ld_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_we,
   output logic [WORD_W-1:0]     mem_wdata,
   input  logic [WORD_W-1:0]     mem_rdata,
   output logic                  pixel_on,
   output logic                  front_bank,
   output logic                  frame_swap,
   output logic                  fetch_overrun
);
   localparam int XW = X_DATA_WIDTH + 1;
   localparam int YW = Y_DATA_WIDTH + 1;
   localparam int RW = YW - SCALE_LOG2;
   localparam logic [XW-1:0]    X_VIS    = XW'(H_AREA);
   localparam logic [YW-1:0]    Y_VIS    = YW'(V_AREA);
   localparam logic [YW-1:0]    Y_LAST   = YW'(V_TOTAL - 1);
   localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(LINE_WORDS - 1);
   localparam logic [OFS_W-1:0] WR_LAST  = OFS_W'(FRAME_WORDS - 1);

   fsm_e              state_q, state_d;
   logic [OFS_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, row_base;
   logic [IDX_W-1:0]  cnt_q, cnt_d, cnt_d1_q;
   logic              dst_q, dst_d, fetch_d1_q;
   logic              back_full_q, back_full_d, front_q, front_d;
   logic              swap_q, swap_d, overrun_q, overrun_d, pixel_q, pixel_d;
   logic [YW-1:0]     next_y;
   logic [RW-1:0]     row;
   logic              trig, rdy, hs, lit, buf_ok;
   logic [WORD_W-1:0] rword;

   always_comb begin
      next_y   = (y_pos == Y_LAST) ? '0 : y_pos + YW'(1);
      row      = next_y[YW-1:SCALE_LOG2];
      row_base = (OFS_W'(row) << 4) + (OFS_W'(row) << 2);
      trig     = pixel_clk_en && (x_pos == X_VIS) && (next_y < Y_VIS)
                 && (next_y[SCALE_LOG2-1:0] == '0);
      rdy      = reset_n && (state_q == IDLE) && !trig && !back_full_q;
      hs       = rdy && ld_valid;
   end

`ifdef FB_UNDERRUN_BLANK_EN
   logic [1:0] valid_q, valid_d;

   always_comb begin
      valid_d = valid_q;
      if (state_q == LAST) valid_d[dst_q] = 1'b1;
      if (trig && (state_q != IDLE)) valid_d[row[0]] = 1'b0;
   end

   always_ff @(posedge CLK_50) begin
      if (!reset_n) valid_q <= '0;
      else          valid_q <= valid_d;
   end

   assign buf_ok = valid_q[y_pos[SCALE_LOG2]];
`else
   assign buf_ok = 1'b1;
`endif

   fb_line_buf u_line_buf (
      .clk_i   (CLK_50),
      .we_i    (fetch_d1_q),
      .wsel_i  (dst_q),
      .waddr_i (cnt_d1_q),
      .wdata_i (mem_rdata),
      .rsel_i  (y_pos[SCALE_LOG2]),
      .raddr_i (x_pos[X_DATA_WIDTH:SCALE_LOG2+3]),
      .rdata_o (rword)
   );

   assign lit = (x_pos < X_VIS) && (y_pos < Y_VIS) && buf_ok
                && rword[3'd7 - x_pos[SCALE_LOG2+2:SCALE_LOG2]];

   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      dst_d       = dst_q;
      wr_ptr_d    = wr_ptr_q;
      back_full_d = back_full_q;
      front_d     = front_q;
      overrun_d   = overrun_q;
      swap_d      = 1'b0;
      pixel_d     = pixel_q;
      case (state_q)
         IDLE: begin
            if (trig) begin
               state_d  = FETCH;
               rd_ptr_d = row_base;
               cnt_d    = '0;
               dst_d    = row[0];
            end
         end
         FETCH: begin
            rd_ptr_d = rd_ptr_q + OFS_W'(1);
            cnt_d    = cnt_q + IDX_W'(1);
            if (cnt_q == CNT_LAST) state_d = LAST;
         end
         LAST:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (trig && (state_q != IDLE)) overrun_d = 1'b1;
      if (hs) begin
         if (wr_ptr_q == WR_LAST) begin
            wr_ptr_d    = '0;
            back_full_d = 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q + OFS_W'(1);
         end
      end
      // Swap only at the first pixel strobe of vertical blank, and only with a complete back frame.
      if (pixel_clk_en && (x_pos == '0) && (y_pos == Y_VIS) && back_full_q) begin
         front_d     = ~front_q;
         back_full_d = 1'b0;
         swap_d      = 1'b1;
      end
      if (pixel_clk_en) pixel_d = lit;
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (reset_n && (state_q == FETCH)) begin
         mem_addr = {front_q, rd_ptr_q};
      end else if (hs) begin
         mem_addr  = {~front_q, wr_ptr_q};
         mem_we    = 1'b1;
         mem_wdata = ld_data;
      end
   end

   always_ff @(posedge CLK_50) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         cnt_d1_q    <= '0;
         dst_q       <= 1'b0;
         fetch_d1_q  <= 1'b0;
         wr_ptr_q    <= '0;
         back_full_q <= 1'b0;
         front_q     <= 1'b0;
         swap_q      <= 1'b0;
         overrun_q   <= 1'b0;
         pixel_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         cnt_d1_q    <= cnt_q;
         dst_q       <= dst_d;
         fetch_d1_q  <= (state_q == FETCH);
         wr_ptr_q    <= wr_ptr_d;
         back_full_q <= back_full_d;
         front_q     <= front_d;
         swap_q      <= swap_d;
         overrun_q   <= overrun_d;
         pixel_q     <= pixel_d;
      end
   end

   assign ld_ready      = rdy;
   assign pixel_on      = pixel_q;
   assign front_bank    = front_q;
   assign frame_swap    = swap_q;
   assign fetch_overrun = overrun_q;
endmodule

// File: tb/tb_fb_fetch_sched.sv
// Directed bench for fb_fetch_sched with a 1-cycle-latency RAM model.
module tb_fb_fetch_sched;
   logic        CLK_50 = 1'b0;
   logic        reset_n = 1'b0;
   logic        pixel_clk_en = 1'b0;
   logic [9:0]  x_pos = '0;
   logic [9:0]  y_pos = '0;
   logic        ld_valid = 1'b0;
   logic [7:0]  ld_data = '0;
   logic        ld_ready;
   logic [12:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;
   logic        pixel_on, front_bank, frame_swap, fetch_overrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] ram [0:8191];

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       exp;
   } pvec_t;
   pvec_t pv [15];

   always #5 CLK_50 = ~CLK_50;

   always @(posedge CLK_50) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   fb_fetch_sched dut (
      .CLK_50        (CLK_50),
      .reset_n       (reset_n),
      .pixel_clk_en  (pixel_clk_en),
      .x_pos         (x_pos),
      .y_pos         (y_pos),
      .ld_valid      (ld_valid),
      .ld_data       (ld_data),
      .ld_ready      (ld_ready),
      .mem_addr      (mem_addr),
      .mem_we        (mem_we),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .pixel_on      (pixel_on),
      .front_bank    (front_bank),
      .frame_swap    (frame_swap),
      .fetch_overrun (fetch_overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_50);
      #1;
   endtask

   function automatic logic [7:0] fdat(input int i);
      return 8'hA5 ^ i[7:0];
   endfunction

   task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic exp, input string name);
      x_pos = x;
      y_pos = y;
      pixel_clk_en = 1'b1;
      tick();
      pixel_clk_en = 1'b0;
      #1;
      chk(name, 32'(pixel_on), 32'(exp));
   endtask

   // Called one cycle after the trigger edge; returns once the FSM is back in IDLE.
   task automatic check_fetch(input string name, input logic [12:0] base);
      int bad = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (mem_we !== 1'b0 || mem_addr !== 13'(base + 13'(k)) || ld_ready !== 1'b0) bad++;
         tick();
      end
      #1;
      if (mem_we !== 1'b0 || ld_ready !== 1'b0) bad++;
      chk(name, 32'(bad), 32'd0);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      pv[0]  = '{10'd0,   10'd0,   1'b1};
      pv[1]  = '{10'd3,   10'd0,   1'b1};
      pv[2]  = '{10'd4,   10'd1,   1'b0};
      pv[3]  = '{10'd7,   10'd2,   1'b0};
      pv[4]  = '{10'd8,   10'd3,   1'b1};
      pv[5]  = '{10'd11,  10'd0,   1'b1};
      pv[6]  = '{10'd12,  10'd1,   1'b0};
      pv[7]  = '{10'd15,  10'd3,   1'b0};
      pv[8]  = '{10'd20,  10'd0,   1'b1};
      pv[9]  = '{10'd16,  10'd2,   1'b0};
      pv[10] = '{10'd31,  10'd2,   1'b1};
      pv[11] = '{10'd32,  10'd0,   1'b1};
      pv[12] = '{10'd63,  10'd1,   1'b0};
      pv[13] = '{10'd700, 10'd0,   1'b0};
      pv[14] = '{10'd0,   10'd480, 1'b0};

      // Reset with a loader byte pending.
      reset_n = 1'b0;
      ld_valid = 1'b1;
      ld_data = 8'h33;
      bad = 0;
      repeat (3) begin
         tick();
         if (mem_we !== 1'b0 || ld_ready !== 1'b0) bad++;
      end
      chk("rst_no_write", 32'(bad), 32'd0);
      chk("rst_pixel_on", 32'(pixel_on), 32'd0);
      chk("rst_front_bank", 32'(front_bank), 32'd0);
      chk("rst_frame_swap", 32'(frame_swap), 32'd0);
      chk("rst_overrun", 32'(fetch_overrun), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      ld_valid = 1'b0;
      reset_n = 1'b1;
      #1;
      chk("rel_ld_ready", 32'(ld_ready), 32'd1);
      chk("rel_front_bank", 32'(front_bank), 32'd0);

      // Fill the back bank.
      bad = 0;
      for (int i = 0; i < 2400; i++) begin
         ld_valid = 1'b1;
         ld_data = fdat(i);
         #1;
         if (mem_we !== 1'b1 || mem_addr !== 13'(32'h1000 + i) ||
             mem_wdata !== fdat(i) || ld_ready !== 1'b1) bad++;
         tick();
      end
      chk("fill_writes", 32'(bad), 32'd0);
      ld_data = 8'hEE;
      #1;
      chk("full_ld_ready", 32'(ld_ready), 32'd0);
      chk("full_no_write", 32'(mem_we), 32'd0);
      ld_valid = 1'b0;

      // Swap at start of vertical blank.
      x_pos = 10'd0;
      y_pos = 10'd480;
      pixel_clk_en = 1'b1;
      tick();
      pixel_clk_en = 1'b0;
      #1;
      chk("swap_pulse", 32'(frame_swap), 32'd1);
      chk("swap_front", 32'(front_bank), 32'd1);
      chk("swap_ld_ready", 32'(ld_ready), 32'd1);
      tick();
      chk("swap_pulse_end", 32'(frame_swap), 32'd0);

      // Last-line trigger fetches row 0 of the new front bank.
      x_pos = 10'd640;
      y_pos = 10'd524;
      pixel_clk_en = 1'b1;
      #1;
      chk("trig_blocks_ready", 32'(ld_ready), 32'd0);
      tick();
      pixel_clk_en = 1'b0;
      check_fetch("wrap_reads", 13'h1000);
      #1;
      chk("idle_after_wrap", 32'(ld_ready), 32'd1);

      for (int i = 0; i < 15; i++)
         pix(pv[i].x, pv[i].y, pv[i].exp, $sformatf("pix x=%0d y=%0d", pv[i].x, pv[i].y));
      chk("no_swap_without_full", 32'(frame_swap), 32'd0);
      chk("front_kept", 32'(front_bank), 32'd1);

      pix(10'd0, 10'd0, 1'b1, "hold_setup");
      x_pos = 10'd4;
      tick();
      chk("pixel_hold", 32'(pixel_on), 32'd1);

      // Row 1 prefetch into buffer 1.
      x_pos = 10'd640;
      y_pos = 10'd3;
      pixel_clk_en = 1'b1;
      tick();
      pixel_clk_en = 1'b0;
      check_fetch("row1_reads", 13'h1014);
      #1;
      chk("idle_after_row1", 32'(ld_ready), 32'd1);
      pix(10'd0,  10'd4, 1'b1, "row1 x=0");
      pix(10'd4,  10'd5, 1'b0, "row1 x=4");
      pix(10'd12, 10'd6, 1'b1, "row1 x=12");
      pix(10'd28, 10'd7, 1'b1, "row1 x=28");

      // Loader held across a trigger.
      ld_valid = 1'b1;
      ld_data = 8'h3C;
      #1;
      chk("coll_first_addr", 32'(mem_addr), 32'h0000);
      chk("coll_first_we", 32'(mem_we), 32'd1);
      tick();
      ld_data = 8'hC3;
      x_pos = 10'd640;
      y_pos = 10'd7;
      pixel_clk_en = 1'b1;
      #1;
      chk("coll_ready_drop", 32'(ld_ready), 32'd0);
      chk("coll_no_write", 32'(mem_we), 32'd0);
      tick();
      pixel_clk_en = 1'b0;
      check_fetch("coll_reads", 13'h1028);
      #1;
      chk("coll_resume_we", 32'(mem_we), 32'd1);
      chk("coll_resume_addr", 32'(mem_addr), 32'h0001);
      chk("coll_resume_data", 32'(mem_wdata), 32'hC3);
      tick();
      ld_valid = 1'b0;

      // Second trigger during a fetch.
      x_pos = 10'd640;
      y_pos = 10'd11;
      pixel_clk_en = 1'b1;
      tick();
      pixel_clk_en = 1'b0;
      #1;
      chk("overrun_clear", 32'(fetch_overrun), 32'd0);
      tick();
      tick();
      pixel_clk_en = 1'b1;
      tick();
      pixel_clk_en = 1'b0;
      #1;
      chk("overrun_set", 32'(fetch_overrun), 32'd1);
      repeat (17) tick();
      chk("overrun_busy", 32'(ld_ready), 32'd0);
      tick();
      chk("overrun_no_restart", 32'(ld_ready), 32'd1);
      repeat (3) tick();
      chk("overrun_sticky", 32'(fetch_overrun), 32'd1);

      // Reset mid-fetch clears FSM, wr_ptr and the sticky flag.
      x_pos = 10'd640;
      y_pos = 10'd15;
      pixel_clk_en = 1'b1;
      tick();
      pixel_clk_en = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      chk("rst_mid_addr", 32'(mem_addr), 32'd0);
      chk("rst_mid_ready", 32'(ld_ready), 32'd0);
      tick();
      chk("rst_mid_overrun", 32'(fetch_overrun), 32'd0);
      chk("rst_mid_front", 32'(front_bank), 32'd0);
      reset_n = 1'b1;
      ld_valid = 1'b1;
      ld_data = 8'h77;
      #1;
      chk("rst_mid_we", 32'(mem_we), 32'd1);
      chk("rst_mid_wr_ptr", 32'(mem_addr), 32'h1000);
      tick();
      ld_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
